// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ID/EX pipeline register layout and operand-extension helper.
package mips_pkg;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Source of the ALU second operand.
    typedef enum logic [1:0] {
        OPB_RT    = 2'd0,
        OPB_SEXT  = 2'd1,
        OPB_ZEXT  = 2'd2,
        OPB_SHAMT = 2'd3
    } opb_sel_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_ctrl;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        beq;
        logic        bne;
        logic        shift;
        logic        use_imm;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } id_ex_t;

    function automatic logic [31:0] ext_operand(opb_sel_e sel, logic [15:0] imm, logic [4:0] shamt);
        logic [31:0] res;
        case (sel)
            OPB_SEXT:  res = {{16{imm[15]}}, imm};
            OPB_ZEXT:  res = {16'd0, imm};
            OPB_SHAMT: res = {27'd0, shamt};
            default:   res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode/funct decoder: ALU code, second-operand source and control flags.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output opb_sel_e   opb_sel,
    output logic       shift,
    output logic       dest_rd,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic       beq,
    output logic       bne
);

    // Decode one instruction; unsupported encodings leave everything at the inert defaults.
    always_comb begin
        alu_ctrl = ALU_NONE;
        opb_sel  = OPB_RT;
        shift    = 1'b0;
        dest_rd  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        beq      = 1'b0;
        bne      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest_rd = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: begin alu_ctrl = ALU_ADD;  regwrite = 1'b1; end
                    F_SUB, F_SUBU: begin alu_ctrl = ALU_SUB;  regwrite = 1'b1; end
                    F_AND:         begin alu_ctrl = ALU_AND;  regwrite = 1'b1; end
                    F_OR:          begin alu_ctrl = ALU_OR;   regwrite = 1'b1; end
                    F_NOR:         begin alu_ctrl = ALU_NOR;  regwrite = 1'b1; end
                    F_SLTU:        begin alu_ctrl = ALU_SLTU; regwrite = 1'b1; end
                    F_SLT:         begin alu_ctrl = ALU_SLT;  regwrite = 1'b1; end
                    F_SLL: begin
                        alu_ctrl = ALU_SLL;
                        regwrite = 1'b1;
                        shift    = 1'b1;
                        opb_sel  = OPB_SHAMT;
                    end
                    F_SRL: begin
                        alu_ctrl = ALU_SRL;
                        regwrite = 1'b1;
                        shift    = 1'b1;
                        opb_sel  = OPB_SHAMT;
                    end
                    default: alu_ctrl = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin alu_ctrl = ALU_ADD;  opb_sel = OPB_SEXT; regwrite = 1'b1; end
            OP_SLTI:           begin alu_ctrl = ALU_SLT;  opb_sel = OPB_SEXT; regwrite = 1'b1; end
            OP_SLTIU:          begin alu_ctrl = ALU_SLTU; opb_sel = OPB_SEXT; regwrite = 1'b1; end
            OP_ANDI:           begin alu_ctrl = ALU_AND;  opb_sel = OPB_ZEXT; regwrite = 1'b1; end
            OP_ORI:            begin alu_ctrl = ALU_OR;   opb_sel = OPB_ZEXT; regwrite = 1'b1; end
            OP_LW: begin
                alu_ctrl = ALU_ADD;
                opb_sel  = OPB_SEXT;
                memread  = 1'b1;
                regwrite = 1'b1;
            end
            OP_SW: begin
                alu_ctrl = ALU_ADD;
                opb_sel  = OPB_SEXT;
                memwrite = 1'b1;
            end
            OP_BEQ: begin alu_ctrl = ALU_SUB; beq = 1'b1; end
            OP_BNE: begin alu_ctrl = ALU_SUB; bne = 1'b1; end
            default: alu_ctrl = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, stall/flush, operand forwarding and load-use detection.
// Optional build macro ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding onto the operands.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_shamt,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_beq,
    output logic        ex_bne,
    output logic        load_use_hazard
);

    logic [3:0]  dec_alu_ctrl;
    opb_sel_e    dec_opb_sel;
    logic        dec_shift;
    logic        dec_dest_rd;
    logic        dec_regwrite;
    logic        dec_memread;
    logic        dec_memwrite;
    logic        dec_beq;
    logic        dec_bne;
    logic [4:0]  dest_sel;
    id_ex_t      nxt;
    id_ex_t      stage_r;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    alu_ctrl_dec u_dec (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .alu_ctrl (dec_alu_ctrl),
        .opb_sel  (dec_opb_sel),
        .shift    (dec_shift),
        .dest_rd  (dec_dest_rd),
        .regwrite (dec_regwrite),
        .memread  (dec_memread),
        .memwrite (dec_memwrite),
        .beq      (dec_beq),
        .bne      (dec_bne)
    );

    assign dest_sel = dec_dest_rd ? id_rd : id_rt;

    // Build the next register image; an invalid ID slot becomes an all-zero bubble.
    always_comb begin
        nxt = '0;
        if (id_valid) begin
            nxt.valid    = 1'b1;
            nxt.alu_ctrl = dec_alu_ctrl;
            // Writes to r0 are architecturally discarded, so never request them.
            nxt.regwrite = dec_regwrite & (dest_sel != 5'd0);
            nxt.memread  = dec_memread;
            nxt.memwrite = dec_memwrite;
            nxt.beq      = dec_beq;
            nxt.bne      = dec_bne;
            nxt.shift    = dec_shift;
            nxt.use_imm  = (dec_opb_sel != OPB_RT);
            nxt.dest     = dest_sel;
            nxt.rs       = id_rs;
            nxt.rt       = id_rt;
            nxt.rs_data  = id_rs_data;
            nxt.rt_data  = id_rt_data;
            nxt.imm      = ext_operand(dec_opb_sel, id_imm, id_shamt);
        end else begin
            nxt = '0;
        end
    end

    // Pipeline register: flush beats stall, reset clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_r <= '0;
        end else if (flush) begin
            stage_r <= '0;
        end else if (!stall) begin
            stage_r <= nxt;
        end else begin
            stage_r <= stage_r;
        end
    end

`ifdef ID_EX_FWD_EN
    // Per-operand forwarding; the younger EX/MEM result takes priority over MEM/WB.
    always_comb begin
        fwd_rs = stage_r.rs_data;
        fwd_rt = stage_r.rt_data;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == stage_r.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == stage_r.rs)) begin
            fwd_rs = memwb_result;
        end else begin
            fwd_rs = stage_r.rs_data;
        end
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == stage_r.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == stage_r.rt)) begin
            fwd_rt = memwb_result;
        end else begin
            fwd_rt = stage_r.rt_data;
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result, stage_r.rs, stage_r.rt};
    assign fwd_rs = stage_r.rs_data;
    assign fwd_rt = stage_r.rt_data;
`endif

    assign ex_valid      = stage_r.valid;
    assign ex_alu_ctrl   = stage_r.alu_ctrl;
    assign ex_dest       = stage_r.dest;
    assign ex_regwrite   = stage_r.regwrite;
    assign ex_memread    = stage_r.memread;
    assign ex_memwrite   = stage_r.memwrite;
    assign ex_beq        = stage_r.beq;
    assign ex_bne        = stage_r.bne;
    // Shifts operate on rt; the shift amount rides in the immediate slot.
    assign ex_in1        = stage_r.shift ? fwd_rt : fwd_rs;
    assign ex_in2        = stage_r.use_imm ? stage_r.imm : fwd_rt;
    assign ex_store_data = fwd_rt;

    assign load_use_hazard = stage_r.valid & stage_r.memread & (stage_r.dest != 5'd0) &
                             ((stage_r.dest == id_rs) | (stage_r.dest == id_rt));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk input 1: sole clock, rising-edge.
REQ-002 SHALL have reset input 1: asynchronous, active-high; one clock, asynchronous active-high reset.
REQ-003 SHALL have stall input 1 (hold register) and flush input 1 (insert bubble).
REQ-004 SHALL have inputs id_valid 1, id_opcode 6, id_funct 6, id_shamt 5, id_imm 16, id_rs/id_rt/id_rd 5 each, id_rs_data/id_rt_data 32 each.
REQ-005 SHALL have forwarding inputs exmem_regwrite 1, exmem_rd 5, exmem_result 32, memwb_regwrite 1, memwb_rd 5, memwb_result 32.
REQ-006 SHALL have outputs ex_valid 1, ex_alu_ctrl 4, ex_in1 32, ex_in2 32 (to ALU InputData1/2), ex_store_data 32, ex_dest 5, ex_regwrite 1, ex_memread 1, ex_memwrite 1, ex_beq 1, ex_bne 1.
REQ-007 SHALL have output load_use_hazard 1 (combinational, to ID stall logic).

Function
REQ-008 On rising clk with flush=1: register loads bubble (valid, regwrite, memread, memwrite, beq, bne, alu_ctrl all 0); flush beats stall.
REQ-009 With stall=1, flush=0: all registered fields hold.
REQ-010 Otherwise: register loads decoded ID fields; id_valid=0 loads a bubble.
REQ-011 ALU codes: ADD 1, SUB 2, SLL 3, SRL 4, AND 5, OR 6, NOR 7, SLTU 8, SLT 9, none 0.
REQ-012 R-type (opcode 0) funct: 0x20/0x21->1, 0x22/0x23->2, 0x00->3, 0x02->4, 0x24->5, 0x25->6, 0x27->7, 0x2B->8, 0x2A->9; dest=rd, regwrite=1.
REQ-013 SLL/SRL: in1 = rt operand, in2 = zero-extended shamt.
REQ-014 I-type: addi 0x08/addiu 0x09->1, slti 0x0A->9, sltiu 0x0B->8 (sign-ext imm); andi 0x0C->5, ori 0x0D->6 (zero-ext imm); dest=rt, regwrite=1.
REQ-015 lw 0x23: code 1, sign-ext imm, memread=1, regwrite=1, dest=rt; sw 0x2B: code 1, sign-ext imm, memwrite=1, regwrite=0.
REQ-016 beq 0x04/bne 0x05: code 2, in2 = rt operand, ex_beq/ex_bne set, regwrite=0.
REQ-017 Unsupported opcode/funct: alu_ctrl 0, all control flags 0, ex_valid still follows id_valid.
REQ-018 Any write with dest=0 SHALL register regwrite=0.
REQ-019 ex_in1/ex_in2/ex_store_data SHALL be combinational from registered operands after forwarding (zero extra latency).
REQ-020 load_use_hazard = ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).

Reset
REQ-021 Reset SHALL force the register to the bubble state immediately, independent of clk, including mid-stall.
REQ-022 After reset: all outputs 0 (operand data registers cleared to 0).

Configuration
REQ-023 Macro ID_EX_FWD_EN defined: per-operand forwarding; source register match with exmem_regwrite & exmem_rd!=0 selects exmem_result, else memwb match selects memwb_result, else registered data; EX/MEM wins when both match.
REQ-024 ID_EX_FWD_EN undefined: forwarding inputs ignored, registered data used; load_use_hazard still produced.

Structure
REQ-025 Shared package mips_pkg SHALL hold ALU code, opcode and funct constants.
REQ-026 Decode SHALL live in combinational sub-module alu_ctrl_dec (opcode, funct -> alu_ctrl, imm-extend select, control flags).

Verification
REQ-027 add rs=1(5), rt=2(7), rd=3 -> next cycle alu_ctrl=1, in1=5, in2=7, dest=3, regwrite=1.
REQ-028 addi imm=0xFFFF vs andi imm=0xFFFF -> in2=0xFFFFFFFF (code 1) vs 0x0000FFFF (code 5).
REQ-029 FWD_EN, rs=4, exmem_rd=4 result 0x11, memwb_rd=4 result 0x22 -> in1=0x11; exmem_rd=0 -> in1=0x22.
REQ-030 stall=1 for 3 cycles with changing ID inputs -> outputs constant; stall=1 & flush=1 -> bubble.
REQ-031 lw dest=8 in EX, ID rs=8 -> load_use_hazard=1; dest=0 -> 0.
REQ-032 reset asserted between clk edges mid-operation -> outputs 0 before next edge.
